// File: rtl/button_bank_if.sv
// Pin-side bundle for the button bank: raw pad inputs and enable in, cleaned state and pulses out.
interface button_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] raw_button_i;
    logic         enable_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] held_o;

    modport master (
        output raw_button_i, enable_i,
        input  level_o, press_o, release_o, held_o
    );

    modport slave (
        input  raw_button_i, enable_i,
        output level_o, press_o, release_o, held_o
    );
endinterface

// File: rtl/button_bank.sv
// N independent button channels: 2-flop sync, stability-window debounce, press/release pulses
// and optional hold-to-repeat press pulses with a held indicator.
module button_bank #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic         clk,
    input  logic         rst_n,
    button_bank_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;
    logic [N-1:0]  level_q;
    logic [N-1:0]  press_q;
    logic [N-1:0]  release_q;
    logic [DW-1:0] db_cnt_q [N];

    logic [N-1:0]  rise;
    logic [N-1:0]  fall;
    logic [N-1:0]  rep_fire;

    // A change is accepted on the sample that completes the stability window.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] != level_q[i] && db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                rise[i] = sync2_q[i];
                fall[i] = ~sync2_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.raw_button_i;
            sync2_q <= sync1_q;
            level_q <= (level_q | rise) & ~fall;
            for (int i = 0; i < N; i++) begin
                if (sync2_q[i] == level_q[i] || rise[i] || fall[i]) begin
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
            // Suppressed pulses are simply dropped, never replayed later.
            press_q   <= bus.enable_i ? (rise | rep_fire) : '0;
            release_q <= bus.enable_i ? fall : '0;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
            localparam int HW   = $clog2(HMAX + 1);

            logic [HW-1:0] hold_cnt_q [N];
            logic [N-1:0]  held_q;

            // Before held rises the counter measures the initial hold, afterwards the repeat period.
            always_comb begin
                rep_fire = '0;
                for (int i = 0; i < N; i++) begin
                    if (level_q[i] && !fall[i]) begin
                        if (held_q[i]) begin
                            rep_fire[i] = (hold_cnt_q[i] == HW'(REPEAT_CYCLES - 1));
                        end else begin
                            rep_fire[i] = (hold_cnt_q[i] == HW'(HOLD_CYCLES - 1));
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    held_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        hold_cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (!level_q[i] || fall[i]) begin
                            hold_cnt_q[i] <= '0;
                            held_q[i]     <= 1'b0;
                        end else if (rep_fire[i]) begin
                            hold_cnt_q[i] <= '0;
                            held_q[i]     <= 1'b1;
                        end else begin
                            hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            assign bus.held_o = held_q;
        end else begin : g_no_repeat
            assign rep_fire   = '0;
            assign bus.held_o = '0;
        end
    endgenerate

    assign bus.level_o   = level_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with a 4-cycle debounce window, 10-cycle hold, 5-cycle repeat.
module tb_button_bank;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    button_bank_if #(.N(N)) bus ();

    button_bank #(
        .N               (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.raw_button_i = '0;
        bus.enable_i = 1'b1;
        #1;
        check("rst_level", 32'(bus.level_o), 32'h0);
        check("rst_press", 32'(bus.press_o), 32'h0);
        check("rst_release", 32'(bus.release_o), 32'h0);
        check("rst_held", 32'(bus.held_o), 32'h0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.raw_button_i = '0;
        bus.enable_i = 1'b1;

        // Clean press on ch0, release after 3 cycles high.
        do_reset();
        bus.raw_button_i = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("clean_press e%0d", e), 32'(bus.press_o), (e == 6) ? 32'h1 : 32'h0);
            check($sformatf("clean_level e%0d", e), 32'(bus.level_o[0]), (e >= 6) ? 32'h1 : 32'h0);
        end
        bus.raw_button_i = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("clean_rel e%0d", e), 32'(bus.release_o), (e == 6) ? 32'h1 : 32'h0);
            check($sformatf("clean_rel_press e%0d", e), 32'(bus.press_o), 32'h0);
            check($sformatf("clean_rel_level e%0d", e), 32'(bus.level_o[0]), (e < 6) ? 32'h1 : 32'h0);
        end

        // Bounce on ch1: 1,0,1,0 for 2 cycles each, then stable 1.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            bus.raw_button_i = (t % 4 < 2) ? 4'b0010 : 4'b0000;
            step();
            check($sformatf("bounce_quiet t%0d", t), 32'(bus.press_o | bus.release_o | bus.level_o), 32'h0);
        end
        bus.raw_button_i = 4'b0010;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("bounce_press e%0d", e), 32'(bus.press_o), (e == 6) ? 32'h2 : 32'h0);
            check($sformatf("bounce_rel e%0d", e), 32'(bus.release_o), 32'h0);
        end

        // Hold-to-repeat on ch2: raw high for 40 edges.
        do_reset();
        bus.raw_button_i = 4'b0100;
        for (int e = 1; e <= 50; e++) begin
            logic exp_p;
            step();
            if (e == 40) bus.raw_button_i = 4'b0000;
            exp_p = (e == 6) || (e == 16) || (e == 21) || (e == 26) || (e == 31) ||
                    (e == 36) || (e == 41);
            check($sformatf("rep_press e%0d", e), 32'(bus.press_o), exp_p ? 32'h4 : 32'h0);
            check($sformatf("rep_held e%0d", e), 32'(bus.held_o), (e >= 16 && e < 46) ? 32'h4 : 32'h0);
            check($sformatf("rep_rel e%0d", e), 32'(bus.release_o), (e == 46) ? 32'h4 : 32'h0);
        end

        // Multi-channel simultaneous press and release.
        do_reset();
        bus.raw_button_i = 4'b1011;
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("multi_press e%0d", e), 32'(bus.press_o), (e == 6) ? 32'hb : 32'h0);
        end
        check("multi_level", 32'(bus.level_o), 32'hb);
        bus.raw_button_i = 4'b0000;
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("multi_rel e%0d", e), 32'(bus.release_o), (e == 6) ? 32'hb : 32'h0);
        end
        check("multi_level_low", 32'(bus.level_o), 32'h0);

        // Enable low across the press: level follows, no pulse now or later.
        do_reset();
        bus.enable_i = 1'b0;
        bus.raw_button_i = 4'b1000;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("en_press e%0d", e), 32'(bus.press_o), 32'h0);
            check($sformatf("en_level e%0d", e), 32'(bus.level_o), (e >= 6) ? 32'h8 : 32'h0);
        end
        bus.enable_i = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("en_late e%0d", e), 32'(bus.press_o | bus.release_o), 32'h0);
        end

        // Reset mid-window (counter at 2) on ch0.
        do_reset();
        bus.raw_button_i = 4'b0001;
        for (int e = 1; e <= 4; e++) step();
        rst_n = 1'b0;
        #1;
        check("midwin_level", 32'(bus.level_o), 32'h0);
        check("midwin_press", 32'(bus.press_o), 32'h0);
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("midwin_after e%0d", e), 32'(bus.press_o), (e == 6) ? 32'h1 : 32'h0);
        end

        // Reset mid-hold on ch2 while held is asserted.
        do_reset();
        bus.raw_button_i = 4'b0100;
        for (int e = 1; e <= 17; e++) step();
        check("midhold_held_pre", 32'(bus.held_o), 32'h4);
        rst_n = 1'b0;
        #1;
        check("midhold_level", 32'(bus.level_o), 32'h0);
        check("midhold_held", 32'(bus.held_o), 32'h0);
        check("midhold_press", 32'(bus.press_o), 32'h0);
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("midhold_after e%0d", e), 32'(bus.press_o), (e == 6) ? 32'h4 : 32'h0);
            check($sformatf("midhold_held_after e%0d", e), 32'(bus.held_o), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
